// File: rtl/ram_vec_pkg.sv
// Shared encodings and default widths for the RAM vector engine.
package ram_vec_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 6;

  // Element-wise operation selected by the command
  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  // Command sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/ram_vec_alu.sv
// Combinational element function f(op, a, b); all results wrap modulo 2^DATA_W.
module ram_vec_alu
  import ram_vec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  // Select the element result; SUB is plain two's complement wrap
  always_comb begin
    result = a;
    case (op)
      OP_COPY: result = a;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_XOR:  result = a ^ b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/ram_vector_engine.sv
// Vector command engine driving a 1-write / 2-async-read RAM.
// Handshake: a command is taken on any posedge where start=1 and ready=1;
// start at any other time is dropped. done pulses for one cycle at the end
// of every command that was not cut short by reset.
// Pipeline: element i is read (async) in one cycle, its result registered at
// the following edge, and written to the RAM during the next cycle.
module ram_vector_engine
  import ram_vec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  output logic              done,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_di,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [ADDR_W-1:0] ram_addr2,
  input  logic [DATA_W-1:0] ram_do1,
  input  logic [DATA_W-1:0] ram_do2
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  state_e              state;
  logic [1:0]          op_r;
  logic [ADDR_W-1:0]   src_a_r;
  logic [ADDR_W-1:0]   src_b_r;
  logic [ADDR_W-1:0]   dst_r;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W-1:0]   idx;
  logic                wvalid;
  logic [ADDR_W:0]     len_clamped;
  logic                last_elem;
  logic [DATA_W-1:0]   alu_res;

  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_elem   = ({1'b0, idx} == (len_r - 1'b1));

  // Read addresses only advance while streaming; parked at 0 otherwise
  assign ram_addr1 = (state == ST_RUN) ? (src_a_r + idx) : '0;
  assign ram_addr2 = (state == ST_RUN) ? (src_b_r + idx) : '0;

  // No RAM write may happen in a cycle where reset is held
  assign ram_we = wvalid & ~RST;

  ram_vec_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_r),
    .a      (ram_do1),
    .b      (ram_do2),
    .result (alu_res)
  );

  // Command FSM, element counter and write-stage registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_r      <= '0;
      src_a_r   <= '0;
      src_b_r   <= '0;
      dst_r     <= '0;
      len_r     <= '0;
      idx       <= '0;
      wvalid    <= 1'b0;
      ram_waddr <= '0;
      ram_di    <= '0;
    end else begin
      wvalid <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r    <= op;
            src_a_r <= src_a;
            src_b_r <= src_b;
            dst_r   <= dst;
            len_r   <= len_clamped;
            idx     <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            if (len_clamped == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          ram_di    <= alu_res;
          ram_waddr <= dst_r + idx;
          wvalid    <= 1'b1;
          if (last_elem) begin
            state <= ST_DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_vector_engine.sv
// Bench for ram_vector_engine with a behavioural 64x16 RAM attached.
module tb_ram_vector_engine;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        ready;
  logic        busy;
  logic        done;
  logic [1:0]  op;
  logic [5:0]  src_a;
  logic [5:0]  src_b;
  logic [5:0]  dst;
  logic [6:0]  len;
  logic        ram_we;
  logic [5:0]  ram_waddr;
  logic [15:0] ram_di;
  logic [5:0]  ram_addr1;
  logic [5:0]  ram_addr2;
  logic [15:0] ram_do1;
  logic [15:0] ram_do2;

  logic [15:0] mem [64];
  logic [15:0] ref_mem [64];

  int checks = 0;
  int errors = 0;

  ram_vector_engine #(.DATA_W(16), .ADDR_W(6)) dut (
    .CLK(CLK), .RST(RST), .start(start), .ready(ready), .busy(busy), .done(done),
    .op(op), .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_di(ram_di),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_do1(ram_do1), .ram_do2(ram_do2)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM: one synchronous write port, two combinational read ports
  assign ram_do1 = mem[ram_addr1];
  assign ram_do2 = mem[ram_addr2];
  always @(posedge CLK) if (ram_we) mem[ram_waddr] <= ram_di;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: element function on plain integers
  function automatic logic [15:0] ref_f(input int o, input int a, input int b);
    int r;
    case (o)
      0: r = a;
      1: r = a + b;
      2: r = a - b;
      default: r = a ^ b;
    endcase
    return 16'(r & 32'hFFFF);
  endfunction

  // Reference: whole-command effect on ref_mem. A write becomes visible
  // to reads two elements later, so each result is committed one step late.
  task automatic model_cmd(input int o, input int sa, input int sb, input int d, input int l);
    int n;
    bit have;
    int p_addr;
    logic [15:0] p_val;
    n = (l > 64) ? 64 : l;
    have = 0;
    p_addr = 0;
    p_val = '0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] r;
      r = ref_f(o, int'(ref_mem[(sa + i) % 64]), int'(ref_mem[(sb + i) % 64]));
      if (have) ref_mem[p_addr] = p_val;
      p_val = r;
      p_addr = (d + i) % 64;
      have = 1;
    end
    if (have) ref_mem[p_addr] = p_val;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
  endtask

  task automatic compare_mem(input string name);
    int bad;
    bad = -1;
    for (int i = 63; i >= 0; i--) if (mem[i] !== ref_mem[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s addr=%0d actual=%0h expected=%0h", name, bad, mem[bad], ref_mem[bad]);
    end
  endtask

  // Driver: issue one command and watch it to completion (cycle 1 = first after accept)
  task automatic run_cmd(input int o, input int sa, input int sb, input int d, input int l,
                         output int done_cyc, output int n_we, output int first_we, output int last_we);
    @(negedge CLK);
    op = 2'(o); src_a = 6'(sa); src_b = 6'(sb); dst = 6'(d); len = 7'(l);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    done_cyc = -1; n_we = 0; first_we = -1; last_we = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      if (c == 1) check("busy_cycle1", {ready, busy}, 2'b01);
      if (ram_we) begin
        n_we++;
        if (first_we < 0) first_we = c;
        last_we = c;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge CLK);
      check("ready_after_done", {ready, busy, done}, 3'b100);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dc, nw, fw, lw;
    logic [15:0] e0, e1, e2, e3;
    int n_done, done_at, n_w;

    RST = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_hs", {ready, busy, done, ram_we}, 4'b1000);
    check("reset_addr", {ram_waddr, ram_addr1, ram_addr2}, 18'h0);
    check("reset_di", ram_di, 16'h0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("idle_hs", {ready, busy, done, ram_we}, 4'b1000);

    // Table-driven single-element vectors: RAM[0]=a, RAM[1]=b -> RAM[2]
    vecs[0] = '{2'b00, 16'h1234, 16'h5555, 16'h1234};
    vecs[1] = '{2'b01, 16'h0001, 16'h0002, 16'h0003};
    vecs[2] = '{2'b01, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[3] = '{2'b10, 16'h0001, 16'hFFFF, 16'h0002};
    vecs[4] = '{2'b10, 16'h0000, 16'h0001, 16'hFFFF};
    vecs[5] = '{2'b11, 16'hA5A5, 16'h0F0F, 16'hAAAA};
    vecs[6] = '{2'b01, 16'h8000, 16'h8000, 16'h0000};
    vecs[7] = '{2'b11, 16'hFFFF, 16'hFFFF, 16'h0000};
    for (int v = 0; v < 8; v++) begin
      mem[0] = vecs[v].a; mem[1] = vecs[v].b; mem[2] = 16'h7777;
      run_cmd(int'(vecs[v].op), 0, 1, 2, 1, dc, nw, fw, lw);
      check($sformatf("vec%0d_result", v), mem[2], vecs[v].exp);
      check($sformatf("vec%0d_done", v), dc, 3);
    end

    // ADD of four elements with cycle-accurate write window
    for (int i = 0; i < 4; i++) begin
      mem[i] = 16'(i + 1); mem[8 + i] = 16'(10 * (i + 1)); mem[16 + i] = '0;
    end
    run_cmd(1, 0, 8, 16, 4, dc, nw, fw, lw);
    check("add_first_we", fw, 2);
    check("add_last_we", lw, 5);
    check("add_n_we", nw, 4);
    check("add_done", dc, 6);
    check("add_vals", {mem[16], mem[17], mem[18], mem[19]}, {16'd11, 16'd22, 16'd33, 16'd44});

    // Address wrap on the source stream
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    e0 = mem[62]; e1 = mem[63]; e2 = mem[0]; e3 = mem[1];
    run_cmd(0, 62, 0, 30, 4, dc, nw, fw, lw);
    check("wrap_vals", {mem[30], mem[31], mem[32], mem[33]}, {e0, e1, e2, e3});

    // Oversized length clamps to the full RAM
    snapshot();
    model_cmd(1, 5, 40, 20, 100);
    run_cmd(1, 5, 40, 20, 100, dc, nw, fw, lw);
    check("clamp_n_we", nw, 64);
    check("clamp_done", dc, 66);
    compare_mem("clamp_mem");

    // Overlap: dst one past src reads pre-write data; dst two past sees writes
    mem[0] = 16'd5; mem[1] = 16'd6; mem[2] = 16'd7; mem[3] = 16'd8;
    run_cmd(0, 0, 0, 1, 3, dc, nw, fw, lw);
    check("overlap1_vals", {mem[1], mem[2], mem[3]}, {16'd5, 16'd6, 16'd7});
    mem[0] = 16'd5; mem[1] = 16'd6; mem[2] = 16'd7; mem[3] = 16'd8;
    run_cmd(0, 0, 0, 2, 4, dc, nw, fw, lw);
    check("overlap2_vals", {mem[2], mem[3], mem[4], mem[5]}, {16'd5, 16'd6, 16'd5, 16'd6});

    // Zero-length command
    run_cmd(1, 0, 0, 0, 0, dc, nw, fw, lw);
    check("len0_done", dc, 1);
    check("len0_n_we", nw, 0);

    // start while busy is dropped
    mem[50] = 16'hBEEF; mem[51] = 16'hBEEF;
    @(negedge CLK);
    op = 2'b01; src_a = 6'd0; src_b = 6'd8; dst = 6'd16; len = 7'd4; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    n_done = 0; done_at = -1; n_w = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (ram_we) n_w++;
      if (done) begin n_done++; done_at = c; end
      if (c == 2) begin
        op = 2'b00; src_a = 6'd0; dst = 6'd50; len = 7'd2; start = 1'b1;
      end
      if (c == 3) start = 1'b0;
    end
    check("busy_start_ndone", n_done, 1);
    check("busy_start_done_at", done_at, 6);
    check("busy_start_n_we", n_w, 4);
    check("busy_start_untouched", {mem[50], mem[51]}, {16'hBEEF, 16'hBEEF});

    // Reset in cycle 5 of a 10-element ADD
    for (int i = 0; i < 10; i++) begin
      mem[i] = 16'(i + 1); mem[20 + i] = 16'(100 * (i + 1)); mem[40 + i] = 16'hDEAD;
    end
    @(negedge CLK);
    op = 2'b01; src_a = 6'd0; src_b = 6'd20; dst = 6'd40; len = 7'd10; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (done) n_done++;
    end
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_we", {ram_we, done}, 2'b00);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_idle", {ready, busy, done}, 3'b100);
    n_w = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (done) n_done++;
      if (ram_we) n_w++;
    end
    check("rst_mid_no_done", n_done, 0);
    check("rst_mid_no_we", n_w, 0);
    for (int i = 0; i < 10; i++)
      check($sformatf("rst_mid_mem%0d", i), mem[40 + i],
            (i < 3) ? 16'((i + 1) * 101) : 16'hDEAD);
    snapshot();
    model_cmd(2, 20, 0, 40, 10);
    run_cmd(2, 20, 0, 40, 10, dc, nw, fw, lw);
    check("rst_after_done", dc, 12);
    compare_mem("rst_after_mem");

    // Randomized commands against the reference model
    for (int t = 0; t < 25; t++) begin
      int ro, rsa, rsb, rd, rl, nexp;
      if (t % 5 == 0) for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      ro = $urandom_range(0, 3);
      rsa = $urandom_range(0, 63);
      rsb = $urandom_range(0, 63);
      rd = $urandom_range(0, 63);
      rl = $urandom_range(0, 80);
      nexp = (rl > 64) ? 64 : rl;
      snapshot();
      model_cmd(ro, rsa, rsb, rd, rl);
      run_cmd(ro, rsa, rsb, rd, rl, dc, nw, fw, lw);
      check($sformatf("rand%0d_done", t), dc, (nexp == 0) ? 1 : nexp + 2);
      check($sformatf("rand%0d_n_we", t), nw, nexp);
      compare_mem($sformatf("rand%0d_mem", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
